// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package data_ram_resp_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NumLegalSel = 7;
    localparam logic [4*NumLegalSel-1:0] LegalSelList = {
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    function automatic logic sel_is_legal(input logic [3:0] sel);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumLegalSel; i++) begin
            if (LegalSelList[4*i +: 4] == sel) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/data_ram_resp_ram_bytewe.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and registered read.
module data_ram_resp_ram_bytewe #(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    localparam int unsigned AddrW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [3:0]       we_i,
    input  logic             re_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// Wait-state data-memory responder for the CPU MEM stage; stalls the pipeline until each access
// completes. Define DATA_RAM_LANE_CHECK_EN to reject irregular byte-lane patterns via lane_err_o.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
`ifdef DATA_RAM_LANE_CHECK_EN
    output logic        lane_err_o,
`endif
    output logic        stallreq_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_sel_q, rd_sel_d;
    logic        enter_done;
    logic        lane_ok;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    // Upper address bits alias and the byte offset is ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[AddrWidth-1:AddrW+2], addr_i[1:0]};

`ifdef DATA_RAM_LANE_CHECK_EN
    logic lane_err_q, lane_err_d;
    assign lane_ok = sel_is_legal(sel_i);
`else
    assign lane_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ce_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                // A dropped request is a pipeline flush: abandon the access.
                if (!ce_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_we   = {4{enter_done & we_i & lane_ok}} & sel_i;
        ram_re   = enter_done & ~we_i & lane_ok;
        rd_sel_d = enter_done ? ram_re : rd_sel_q;
`ifdef DATA_RAM_LANE_CHECK_EN
        lane_err_d = enter_done & ~lane_ok;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rd_sel_q <= 1'b0;
`ifdef DATA_RAM_LANE_CHECK_EN
            lane_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
`ifdef DATA_RAM_LANE_CHECK_EN
            lane_err_q <= lane_err_d;
`endif
        end
    end

    data_ram_resp_ram_bytewe #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (addr_i[AddrW+1:2]),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .wdata_i (data_i),
        .rdata_o (ram_rdata)
    );

    // The RAM output register only loads on reads; writes and errors present zero instead.
    assign data_o     = rd_sel_q ? ram_rdata : 32'h0;
    assign stallreq_o = ce_i & (state_q != StDone);
`ifdef DATA_RAM_LANE_CHECK_EN
    assign lane_err_o = lane_err_q;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with two wait states, one with none.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we, ce0, we0;
    logic [31:0] addr, data_in, addr0, data_in0;
    logic [3:0]  sel, sel0;
    logic [31:0] data_out, data_out0;
    logic        stall, stall0;
`ifdef DATA_RAM_LANE_CHECK_EN
    logic        lane_err, lane_err0;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce),
        .we_i       (we),
        .addr_i     (addr),
        .sel_i      (sel),
        .data_i     (data_in),
        .data_o     (data_out),
`ifdef DATA_RAM_LANE_CHECK_EN
        .lane_err_o (lane_err),
`endif
        .stallreq_o (stall)
    );

    data_ram_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce0),
        .we_i       (we0),
        .addr_i     (addr0),
        .sel_i      (sel0),
        .data_i     (data_in0),
        .data_o     (data_out0),
`ifdef DATA_RAM_LANE_CHECK_EN
        .lane_err_o (lane_err0),
`endif
        .stallreq_o (stall0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the start of the next cycle, clear of the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full access on the two-wait-state instance; returns with ce low in the cycle after DONE.
    task automatic acc(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp, input logic exp_err,
                       input string tag);
        ce = 1'b1; we = w; addr = a; sel = s; data_in = d;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_stall_hi"}, {31'h0, stall}, 32'h1);
`ifdef DATA_RAM_LANE_CHECK_EN
            chk({tag, "_lerr_lo"}, {31'h0, lane_err}, 32'h0);
`endif
            step();
        end
        chk({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
        chk({tag, "_data"}, data_out, exp);
`ifdef DATA_RAM_LANE_CHECK_EN
        chk({tag, "_lerr_done"}, {31'h0, lane_err}, {31'h0, exp_err});
`else
        if (exp_err) $display("note: %s expects a lane error only with lane checking", tag);
`endif
        step();
        ce = 1'b0;
        #1;
`ifdef DATA_RAM_LANE_CHECK_EN
        chk({tag, "_lerr_after"}, {31'h0, lane_err}, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_in = '0;
        ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; data_in0 = '0;
        step();
        step();
        chk("rst_data", data_out, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_data0", data_out0, 32'h0);
        chk("rst_stall0", {31'h0, stall0}, 32'h0);
        rst = 1'b0;
        step();

        acc(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, "wr10");
        acc(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");

        acc(1'b1, 32'h20, 4'b1111, 32'h11223344, 32'h0, 1'b0, "wr20");
        acc(1'b1, 32'h20, 4'b0100, 32'h00AA0000, 32'h0, 1'b0, "wr20_lane2");
        acc(1'b0, 32'h20, 4'b1111, 32'h0, 32'h11AA3344, 1'b0, "rd20");

        acc(1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, "wr_alias");
        acc(1'b0, 32'h0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, "rd_alias");

        // sel 0000 is also an irregular pattern when lane checking is on.
        acc(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1, "wr_sel0");
        acc(1'b0, 32'h20, 4'b1111, 32'h0, 32'h11AA3344, 1'b0, "rd_sel0");

        // Abort: write presented in cycle 0, ce dropped in cycle 1.
        ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'b1111; data_in = 32'h0BADF00D;
        #1;
        chk("abort_stall_c0", {31'h0, stall}, 32'h1);
        step();
        ce = 1'b0;
        #1;
        chk("abort_stall_c1", {31'h0, stall}, 32'h0);
        chk("abort_data_c1", data_out, 32'h11AA3344);
        step();
        // A fresh read from cycle 2 must see full latency (state was IDLE) and old memory.
        acc(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, "abort_rd");

        // Reset during WAIT.
        ce = 1'b1; we = 1'b0; addr = 32'h20; sel = 4'b1111;
        step();
        rst = 1'b1;
        #1;
        chk("rstmid_data", data_out, 32'h0);
        chk("rstmid_stall", {31'h0, stall}, 32'h1);
        ce = 1'b0;
        step();
        rst = 1'b0;
        step();
        acc(1'b0, 32'h20, 4'b1111, 32'h0, 32'h11AA3344, 1'b0, "rstmid_rd");

`ifdef DATA_RAM_LANE_CHECK_EN
        acc(1'b1, 32'h10, 4'b0110, 32'hFFFFFFFF, 32'h0, 1'b1, "lane_wr0110");
        acc(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, "lane_rd");
        acc(1'b0, 32'h10, 4'b0101, 32'h0, 32'h0, 1'b1, "lane_rd0101");
        acc(1'b1, 32'h10, 4'b0011, 32'h0000BEEF, 32'h0, 1'b0, "lane_wr0011");
`endif

        // Zero-wait instance.
        ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; sel0 = 4'b1111; data_in0 = 32'h12345678;
        #1;
        chk("w0_wr_stall_c0", {31'h0, stall0}, 32'h1);
        step();
        chk("w0_wr_stall_c1", {31'h0, stall0}, 32'h0);
        chk("w0_wr_data_c1", data_out0, 32'h0);
        step();
        addr0 = 32'h4; data_in0 = 32'h9ABCDEF0;
        #1;
        chk("w0_wr4_stall_c0", {31'h0, stall0}, 32'h1);
        step();
        chk("w0_wr4_stall_c1", {31'h0, stall0}, 32'h0);
        step();
        // Back-to-back reads with ce held high: two cycles each.
        we0 = 1'b0; addr0 = 32'h0;
        #1;
        chk("w0_rd0_stall_c0", {31'h0, stall0}, 32'h1);
        step();
        chk("w0_rd0_stall_c1", {31'h0, stall0}, 32'h0);
        chk("w0_rd0_data_c1", data_out0, 32'h12345678);
        step();
        addr0 = 32'h4;
        #1;
        chk("w0_rd4_stall_c2", {31'h0, stall0}, 32'h1);
        chk("w0_rd4_hold_c2", data_out0, 32'h12345678);
        step();
        chk("w0_rd4_stall_c3", {31'h0, stall0}, 32'h0);
        chk("w0_rd4_data_c3", data_out0, 32'h9ABCDEF0);
        step();
        ce0 = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
